// File: rtl/leds_controller_if.sv
// Control lines from the LED bus interface and the pin/status lines returned by the controller.
// The bus side drives the requests; the controller drives the pins and busy.
interface leds_controller_if;
   logic ctrl_en;
   logic ctrl_led0;
   logic ctrl_led1;
   logic ctrl_led2;
   logic ctrl_led3;
   logic led0;
   logic led1;
   logic led2;
   logic led3;
   logic busy;

   modport master (
      output ctrl_en, ctrl_led0, ctrl_led1, ctrl_led2, ctrl_led3,
      input  led0, led1, led2, led3, busy
   );

   modport slave (
      input  ctrl_en, ctrl_led0, ctrl_led1, ctrl_led2, ctrl_led3,
      output led0, led1, led2, led3, busy
   );
endinterface

// File: rtl/leds_controller.sv
// Four-LED soft-fade driver: each duty level ramps one step per prescaler tick toward its
// target, and a free-running PWM counter renders the current duty on the registered pin.
module leds_controller #(
   parameter int PWM_BITS      = 8,
   parameter int FADE_PRESCALE = 1024,
   parameter bit ACTIVE_LOW    = 1'b0
) (
   input logic clk,
   input logic rst,
   leds_controller_if.slave bus
);
   localparam logic [PWM_BITS-1:0] FULL = '1;
   localparam int PRE_W = (FADE_PRESCALE > 1) ? $clog2(FADE_PRESCALE) : 1;
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(FADE_PRESCALE - 1);

   logic                en_q;
   logic [3:0]          led_q;
   logic [PWM_BITS-1:0] pwm_cnt;
   logic [PRE_W-1:0]    pre_cnt;
   logic                tick;
   logic [PWM_BITS-1:0] duty [4];
   logic [PWM_BITS-1:0] duty_next [4];
   logic [PWM_BITS-1:0] target [4];
   logic [3:0]          lit;
   logic [3:0]          led_r;
   logic                busy_r;
   logic                busy_next;

   // With a prescale of 1 the counter never leaves 0, so tick stays high every cycle.
   assign tick = (pre_cnt == PRE_LAST);

   always_comb begin
      busy_next = 1'b0;
      lit       = '0;
      for (int i = 0; i < 4; i++) begin
         target[i]    = (en_q && led_q[i]) ? FULL : '0;
         duty_next[i] = duty[i];
         if (tick) begin
            if (duty[i] < target[i]) begin
               duty_next[i] = duty[i] + PWM_BITS'(1);
            end else if (duty[i] > target[i]) begin
               duty_next[i] = duty[i] - PWM_BITS'(1);
            end
         end
         // Busy looks at the duty being written this cycle, not the one being replaced.
         if (duty_next[i] != target[i]) begin
            busy_next = 1'b1;
         end
         lit[i] = (duty[i] == FULL) || (duty[i] > pwm_cnt);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         en_q    <= 1'b0;
         led_q   <= '0;
         pwm_cnt <= '0;
         pre_cnt <= '0;
         for (int i = 0; i < 4; i++) begin
            duty[i] <= '0;
         end
         led_r   <= {4{ACTIVE_LOW}};
         busy_r  <= 1'b0;
      end else begin
         en_q    <= bus.ctrl_en;
         led_q   <= {bus.ctrl_led3, bus.ctrl_led2, bus.ctrl_led1, bus.ctrl_led0};
         pwm_cnt <= pwm_cnt + PWM_BITS'(1);
         pre_cnt <= tick ? '0 : pre_cnt + PRE_W'(1);
         for (int i = 0; i < 4; i++) begin
            duty[i] <= duty_next[i];
         end
         led_r   <= lit ^ {4{ACTIVE_LOW}};
         busy_r  <= busy_next;
      end
   end

   assign bus.led0 = led_r[0];
   assign bus.led1 = led_r[1];
   assign bus.led2 = led_r[2];
   assign bus.led3 = led_r[3];
   assign bus.busy = busy_r;
endmodule

// File: tb/tb_leds_controller.sv
// Directed bench for leds_controller: three instances (fast fade, slow fade, active-low)
// with expected pin/busy timing derived by hand from cycles elapsed since each reset.
module tb_leds_controller;
   logic clk = 1'b0;
   logic rst_a = 1'b1;
   logic rst_b = 1'b1;
   logic rst_c = 1'b1;
   int   s_a = 0;
   int   s_b = 0;
   int   s_c = 0;
   int   checks = 0;
   int   errors = 0;

   leds_controller_if bus_a ();
   leds_controller_if bus_b ();
   leds_controller_if bus_c ();

   leds_controller #(.PWM_BITS(4), .FADE_PRESCALE(2), .ACTIVE_LOW(1'b0)) dut_a (
      .clk(clk), .rst(rst_a), .bus(bus_a)
   );
   leds_controller #(.PWM_BITS(4), .FADE_PRESCALE(256), .ACTIVE_LOW(1'b0)) dut_b (
      .clk(clk), .rst(rst_b), .bus(bus_b)
   );
   leds_controller #(.PWM_BITS(4), .FADE_PRESCALE(256), .ACTIVE_LOW(1'b1)) dut_c (
      .clk(clk), .rst(rst_c), .bus(bus_c)
   );

   logic [3:0] leds_a;
   logic [3:0] leds_b;
   logic [3:0] leds_c;
   assign leds_a = {bus_a.led3, bus_a.led2, bus_a.led1, bus_a.led0};
   assign leds_b = {bus_b.led3, bus_b.led2, bus_b.led1, bus_b.led0};
   assign leds_c = {bus_c.led3, bus_c.led2, bus_c.led1, bus_c.led0};

   always #5 clk = ~clk;

   // Edges elapsed since the last sampled reset of each instance; fixes the tick and PWM phase.
   always @(posedge clk) begin
      s_a <= rst_a ? 0 : s_a + 1;
      s_b <= rst_b ? 0 : s_b + 1;
      s_c <= rst_c ? 0 : s_c + 1;
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drive_a(input logic en, input logic [3:0] req);
      bus_a.ctrl_en   = en;
      bus_a.ctrl_led0 = req[0];
      bus_a.ctrl_led1 = req[1];
      bus_a.ctrl_led2 = req[2];
      bus_a.ctrl_led3 = req[3];
   endtask

   // Leaves the next edge as E0 so that E1, E3, E5 ... are fade ticks on instance a.
   task automatic align_a();
      while (s_a % 2 != 0) step(1);
   endtask

   task automatic test_reset();
      drive_a(1'b0, 4'b0000);
      rst_a = 1'b1;
      step(2);
      rst_a = 1'b0;
      checks++;
      if ({bus_a.busy, leds_a} !== 5'b0_0000) begin
         errors++;
         $display("[TB] FAIL reset_state: got busy/leds %b, expected 00000", {bus_a.busy, leds_a});
      end
      drive_a(1'b0, 4'b1111);
      for (int i = 0; i < 100; i++) begin
         step(1);
         checks++;
         if ({bus_a.busy, leds_a} !== 5'b0_0000) begin
            errors++;
            $display("[TB] FAIL idle_disabled cycle %0d: got busy/leds %b, expected 00000", i, {bus_a.busy, leds_a});
         end
      end
   endtask

   task automatic test_fade_in();
      int n;
      align_a();
      drive_a(1'b1, 4'b0001);
      step(1);
      checks++;
      if (bus_a.busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL fade_in_busy_e0: got %b, expected 0", bus_a.busy);
      end
      step(1);
      checks++;
      if (bus_a.busy !== 1'b1) begin
         errors++;
         $display("[TB] FAIL fade_in_busy_rise: got %b, expected 1", bus_a.busy);
      end
      step(27);
      checks++;
      if (bus_a.busy !== 1'b1) begin
         errors++;
         $display("[TB] FAIL fade_in_busy_e28: got %b, expected 1", bus_a.busy);
      end
      step(1);
      checks++;
      if (bus_a.busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL fade_in_busy_fall: got %b, expected 0", bus_a.busy);
      end
      step(1);
      for (int i = 0; i < 32; i++) begin
         checks++;
         if (leds_a !== 4'b0001) begin
            errors++;
            $display("[TB] FAIL fade_in_full_on cycle %0d: got leds %b, expected 0001", i, leds_a);
         end
         step(1);
      end
      drive_a(1'b1, 4'b0000);
      step(2);
      n = 0;
      while (bus_a.busy !== 1'b0 && n < 40) begin
         step(1);
         n++;
      end
      checks++;
      if (n >= 40) begin
         errors++;
         $display("[TB] FAIL fade_out_timeout: busy still %b after %0d cycles, expected 0", bus_a.busy, n);
      end
      step(1);
      for (int i = 0; i < 16; i++) begin
         checks++;
         if (leds_a !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL fade_out_dark cycle %0d: got leds %b, expected 0000", i, leds_a);
         end
         step(1);
      end
   endtask

   task automatic test_reversal();
      align_a();
      drive_a(1'b1, 4'b0001);
      step(16);
      drive_a(1'b1, 4'b0000);
      step(1);
      checks++;
      if (bus_a.busy !== 1'b1) begin
         errors++;
         $display("[TB] FAIL reversal_busy_e16: got %b, expected 1", bus_a.busy);
      end
      step(14);
      checks++;
      if (bus_a.busy !== 1'b1) begin
         errors++;
         $display("[TB] FAIL reversal_busy_e30: got %b, expected 1", bus_a.busy);
      end
      step(1);
      checks++;
      if (bus_a.busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reversal_busy_fall: got %b, expected 0", bus_a.busy);
      end
      step(1);
      for (int i = 0; i < 16; i++) begin
         checks++;
         if (leds_a !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL reversal_dark cycle %0d: got leds %b, expected 0000", i, leds_a);
         end
         step(1);
      end
   endtask

   task automatic test_sync_reset();
      align_a();
      drive_a(1'b1, 4'b1111);
      step(14);
      rst_a = 1'b1;
      step(1);
      rst_a = 1'b0;
      checks++;
      if ({bus_a.busy, leds_a} !== 5'b0_0000) begin
         errors++;
         $display("[TB] FAIL midfade_reset: got busy/leds %b, expected 00000", {bus_a.busy, leds_a});
      end
      step(1);
      checks++;
      if ({bus_a.busy, leds_a} !== 5'b0_0000) begin
         errors++;
         $display("[TB] FAIL post_reset_s1: got busy/leds %b, expected 00000", {bus_a.busy, leds_a});
      end
      step(1);
      checks++;
      if (bus_a.busy !== 1'b1) begin
         errors++;
         $display("[TB] FAIL post_reset_busy_rise: got %b, expected 1", bus_a.busy);
      end
      step(8);
      rst_a = 1'b1;
      #2;
      rst_a = 1'b0;
      step(19);
      checks++;
      if (bus_a.busy !== 1'b1) begin
         errors++;
         $display("[TB] FAIL refade_busy_s29: got %b, expected 1", bus_a.busy);
      end
      step(1);
      checks++;
      if (bus_a.busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL refade_busy_fall: got %b, expected 0", bus_a.busy);
      end
      step(1);
      for (int i = 0; i < 16; i++) begin
         checks++;
         if (leds_a !== 4'b1111) begin
            errors++;
            $display("[TB] FAIL refade_all_on cycle %0d: got leds %b, expected 1111", i, leds_a);
         end
         step(1);
      end
   endtask

   task automatic test_duty_accuracy();
      int hi;
      logic exp_on;
      bus_b.ctrl_en   = 1'b0;
      bus_b.ctrl_led0 = 1'b0;
      bus_b.ctrl_led1 = 1'b0;
      bus_b.ctrl_led2 = 1'b0;
      bus_b.ctrl_led3 = 1'b0;
      rst_b = 1'b1;
      step(1);
      rst_b = 1'b0;
      bus_b.ctrl_en   = 1'b1;
      bus_b.ctrl_led0 = 1'b1;
      while (s_b < 1295) step(1);
      hi = 0;
      for (int i = 0; i < 16; i++) begin
         step(1);
         exp_on = (s_b % 16 >= 1) && (s_b % 16 <= 5);
         checks++;
         if (leds_b !== {3'b000, exp_on}) begin
            errors++;
            $display("[TB] FAIL duty5_pattern phase %0d: got leds %b, expected %b", s_b % 16, leds_b, {3'b000, exp_on});
         end
         if (bus_b.led0 === 1'b1) hi++;
      end
      checks++;
      if (hi != 5) begin
         errors++;
         $display("[TB] FAIL duty5_count: got %0d high cycles, expected 5", hi);
      end
   endtask

   task automatic test_active_low();
      int lo;
      logic exp_pin;
      bus_c.ctrl_en   = 1'b0;
      bus_c.ctrl_led0 = 1'b0;
      bus_c.ctrl_led1 = 1'b0;
      bus_c.ctrl_led2 = 1'b0;
      bus_c.ctrl_led3 = 1'b0;
      rst_c = 1'b1;
      step(1);
      rst_c = 1'b0;
      checks++;
      if ({bus_c.busy, leds_c} !== 5'b0_1111) begin
         errors++;
         $display("[TB] FAIL active_low_reset: got busy/leds %b, expected 01111", {bus_c.busy, leds_c});
      end
      bus_c.ctrl_en   = 1'b1;
      bus_c.ctrl_led0 = 1'b1;
      while (s_c < 1295) step(1);
      lo = 0;
      for (int i = 0; i < 16; i++) begin
         step(1);
         exp_pin = !((s_c % 16 >= 1) && (s_c % 16 <= 5));
         checks++;
         if (leds_c !== {3'b111, exp_pin}) begin
            errors++;
            $display("[TB] FAIL active_low_duty5 phase %0d: got leds %b, expected %b", s_c % 16, leds_c, {3'b111, exp_pin});
         end
         if (bus_c.led0 === 1'b0) lo++;
      end
      checks++;
      if (lo != 5) begin
         errors++;
         $display("[TB] FAIL active_low_duty5_count: got %0d low cycles, expected 5", lo);
      end
      checks++;
      if (bus_c.busy !== 1'b1) begin
         errors++;
         $display("[TB] FAIL active_low_busy_mid: got %b, expected 1", bus_c.busy);
      end
      while (s_c < 3855) step(1);
      for (int i = 0; i < 16; i++) begin
         step(1);
         checks++;
         if (leds_c !== 4'b1110) begin
            errors++;
            $display("[TB] FAIL active_low_full cycle %0d: got leds %b, expected 1110", i, leds_c);
         end
      end
      checks++;
      if (bus_c.busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL active_low_busy_done: got %b, expected 0", bus_c.busy);
      end
   endtask

   initial begin
      drive_a(1'b0, 4'b0000);
      bus_b.ctrl_en   = 1'b0;
      bus_b.ctrl_led0 = 1'b0;
      bus_b.ctrl_led1 = 1'b0;
      bus_b.ctrl_led2 = 1'b0;
      bus_b.ctrl_led3 = 1'b0;
      bus_c.ctrl_en   = 1'b0;
      bus_c.ctrl_led0 = 1'b0;
      bus_c.ctrl_led1 = 1'b0;
      bus_c.ctrl_led2 = 1'b0;
      bus_c.ctrl_led3 = 1'b0;
      $display("[TB] starting leds_controller tests");
      test_reset();
      test_fade_in();
      test_reversal();
      test_sync_reset();
      test_duty_accuracy();
      test_active_low();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/leds_controller.md
Name: leds_controller

Overview:
- Downstream consumer of the LED bus-interface control lines: takes the global enable and four per-LED on/off requests and drives the board LED pins.
- Each LED gets a soft fade: a per-LED duty level ramps toward its target at a fixed rate, and a free-running PWM comparator renders the current duty on the pin.
- A busy flag reports any fade still in progress.

Parameters:
- PWM_BITS, 8, width of the PWM counter and of each duty register; full scale is FULL = 2^PWM_BITS-1.
- FADE_PRESCALE, 1024, clocks per duty step (must be >=1; 1 means a step every cycle).
- ACTIVE_LOW, 0, 1 inverts all LED pin outputs (lit = 0).

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous active-high reset, sampled on posedge clk.
- ctrl_en  input  1  global enable from the bus interface.
- ctrl_led0..ctrl_led3  input  1 each  per-LED on request.
- led0..led3  output  1 each  registered LED pin drive.
- busy  output  1  high while any duty differs from its target.

Behaviour:
- Only one clock domain exists. Reset is synchronous and active-high; all state changes happen on posedge clk.
- Reset values:
  - Input sample registers 0.
  - pwm_cnt 0, prescale count 0, all duty_i 0.
  - led0..led3 = ACTIVE_LOW (off).
  - busy 0.
- rst has priority over every other update in the same cycle.
- Input stage: ctrl_en and ctrl_led0..3 are registered once; target_i = (en_q && led_q[i]) ? FULL : 0.
  - A new request therefore affects targets one cycle after it appears.
- PWM counter: pwm_cnt is PWM_BITS wide, increments every cycle and wraps FULL -> 0. One PWM period is 2^PWM_BITS cycles.
- Prescaler:
  - Counts 0..FADE_PRESCALE-1 and then wraps to 0.
  - tick is asserted for exactly one cycle in the cycle the count equals FADE_PRESCALE-1.
  - When FADE_PRESCALE = 1, tick is high every cycle.
- Duty update happens only on tick, per LED:
  - duty_i < target_i -> duty_i + 1.
  - duty_i > target_i -> duty_i - 1.
  - Equal -> hold.
  - Step size is 1, so duty never overshoots and needs no saturation logic.
- Target change mid-fade: the direction reverses at the next tick, with no restart from 0 or FULL.
- ctrl_en low: all targets go to 0 and all LEDs fade out at the normal rate. There is no instant-off path.
- Compare:
  - lit_i = (duty_i == FULL) || (duty_i > pwm_cnt).
  - duty 0 -> never lit.
  - duty FULL -> always lit.
  - 0 < d < FULL -> lit for exactly d cycles per PWM period, at pwm_cnt 0..d-1.
- Output: led_i <= lit_i ^ ACTIVE_LOW is registered, so the pin lags the compare by 1 cycle.
- busy is registered: busy <= OR over i of (duty_i != target_i), evaluated on the post-update values.
- Fade duration: 0 -> FULL takes FULL ticks, i.e. FULL*FADE_PRESCALE cycles, plus 1 input and 1 output cycle of latency.
- Prescaler and pwm_cnt free-run and are independent of requests. The first step after a request can therefore come anywhere from 1 to FADE_PRESCALE cycles after the target changes.
- Reset mid-fade: the cycle after the rst edge, all duties are 0 and all pins are off. Fading resumes from 0 after rst deasserts if the inputs still request on.
- rst pulsed between edges without being sampled has no effect.

Test Plan:
Bench instance: PWM_BITS=4, FADE_PRESCALE=2, ACTIVE_LOW=0 unless noted.
1. Reset and idle: assert rst for 2 cycles, then hold ctrl_en=0 with all ctrl_led=1 for 100 cycles -> led0..3 = 0 and busy = 0 throughout.
2. Fade in: ctrl_en=1, ctrl_led0=1 -> busy rises within 2 cycles.
   - duty0 reaches 15 after 15 ticks (about 30 cycles), and busy falls in the following cycle.
   - led0 then stays constantly 1; led1..3 stay 0.
3. Reversal: from test 2 at duty0 = 8, drop ctrl_led0.
   - duty0 decrements from the next tick and reaches 0 after 8 ticks.
   - busy then falls and led0 stays constantly 0.
4. Duty accuracy: instance with FADE_PRESCALE=256; let duty0 step to 5, then sample led0 over one full 16-cycle PWM period while duty is constant.
   - Exactly 5 high cycles, contiguous, starting 1 cycle after pwm_cnt = 0.
5. Sync reset mid-fade: all four LEDs fading with duty = 7, rst high for one edge.
   - Next cycle: all duties 0, led0..3 = 0, busy = 0.
   - After rst drops with inputs still on, fade restarts from 0.
   - An rst glitch between edges causes no change.
6. Active-low: instance with ACTIVE_LOW=1.
   - After reset, led0..3 = 1.
   - Fully on LED -> 0 constantly; duty 5 -> 0 for exactly 5 cycles per period.
